// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button debouncer.
package btn_pkg;

   localparam int N_BTN_DEFAULT       = 4;
   localparam int DEBOUNCE_CYCLES_HW  = 1000000;
   localparam int DEBOUNCE_CYCLES_SIM = 4;

   typedef logic [N_BTN_DEFAULT-1:0] btn_vec_t;

endpackage : btn_pkg

// File: rtl/btn_debounce_cell.sv
// One button: 2-flop synchroniser, stability counter, debounced level and edge pulses.
// Optional toggle output is built only when BTN_DEBOUNCER_TOGGLE_EN is defined.
module btn_debounce_cell
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic db_o,
   output logic press_o,
   output logic release_o,
   output logic toggle_o
);

   localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync_q;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             db_q,      db_d;
   logic             press_q,   press_d;
   logic             release_q, release_d;

   // Pulses are set on the same edge that db_q takes its new value, so they
   // line up with the first cycle the new level is visible.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      cnt_d     = '0;
      db_d      = db_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync_q != db_q) begin
         if (cnt_q == CNT_MAX) begin
            db_d      = sync_q;
            press_d   = sync_q;
            release_d = ~sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // NOTE: reset is synchronous, so it lives inside the clocked branch and
   // only takes effect on a rising edge; state uses non-blocking assignments.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync_q    <= 1'b0;
         cnt_q     <= '0;
         db_q      <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= btn_i;
         sync_q    <= sync1_q;
         cnt_q     <= cnt_d;
         db_q      <= db_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

`ifdef BTN_DEBOUNCER_TOGGLE_EN
   logic toggle_q;

   always_ff @(posedge clk) begin
      if (!rst_n) toggle_q <= 1'b0;
      else        toggle_q <= toggle_q ^ press_q;
   end

   assign toggle_o = toggle_q;
`else
   assign toggle_o = 1'b0;
`endif

   assign db_o      = db_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule : btn_debounce_cell

// File: rtl/btn_debouncer.sv
// Parallel debouncer for N_BTN raw push-buttons; one independent cell per button.
// Define BTN_DEBOUNCER_TOGGLE_EN to enable the per-button toggle outputs.
module btn_debouncer
   import btn_pkg::*;
#(
   parameter int N_BTN           = N_BTN_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_i,
   output logic [N_BTN-1:0] btn_db_o,
   output logic [N_BTN-1:0] btn_press_o,
   output logic [N_BTN-1:0] btn_release_o,
   output logic [N_BTN-1:0] btn_toggle_o
);

   for (genvar k = 0; k < N_BTN; k++) begin : g_cell
      btn_debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .clk      (clk),
         .rst_n    (rst_n),
         .btn_i    (btn_i[k]),
         .db_o     (btn_db_o[k]),
         .press_o  (btn_press_o[k]),
         .release_o(btn_release_o[k]),
         .toggle_o (btn_toggle_o[k])
      );
   end

endmodule : btn_debouncer

// File: tb/tb_btn_debouncer.sv
// Self-checking bench for btn_debouncer: directed scenarios plus random button
// activity, compared each cycle against a run-length reference model.
module tb_btn_debouncer;
   import btn_pkg::*;

   localparam int NB = N_BTN_DEFAULT;
   localparam int DC = DEBOUNCE_CYCLES_SIM;

   logic     clk = 1'b0;
   logic     rst_n;
   btn_vec_t btn_i;
   btn_vec_t btn_db_o, btn_press_o, btn_release_o, btn_toggle_o;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   btn_debouncer #(
      .N_BTN          (NB),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_i        (btn_i),
      .btn_db_o     (btn_db_o),
      .btn_press_o  (btn_press_o),
      .btn_release_o(btn_release_o),
      .btn_toggle_o (btn_toggle_o)
   );

   task automatic check(input string tag, input btn_vec_t obs, input btn_vec_t exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: the level seen by the filter is btn_i delayed two edges;
   // the output adopts a level once it has been seen on DC consecutive edges.
   btn_vec_t m_pipe [2];
   btn_vec_t m_db, m_press, m_rel, m_tog;
   int       m_run  [NB];
   logic     m_last [NB];

   task automatic model_edge();
      btn_vec_t seen;
      if (!rst_n) begin
         m_pipe[0] = '0; m_pipe[1] = '0;
         m_db = '0; m_press = '0; m_rel = '0; m_tog = '0;
         for (int k = 0; k < NB; k++) begin
            m_run[k]  = 0;
            m_last[k] = 1'b0;
         end
      end else begin
         seen = m_pipe[1];
`ifdef BTN_DEBOUNCER_TOGGLE_EN
         m_tog = m_tog ^ m_press;
`endif
         for (int k = 0; k < NB; k++) begin
            if (m_run[k] == 0 || seen[k] != m_last[k]) m_run[k] = 1;
            else                                       m_run[k] = m_run[k] + 1;
            m_last[k]  = seen[k];
            m_press[k] = 1'b0;
            m_rel[k]   = 1'b0;
            if (m_run[k] >= DC && seen[k] != m_db[k]) begin
               m_db[k]    = seen[k];
               m_press[k] = seen[k];
               m_rel[k]   = ~seen[k];
            end
         end
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = btn_i;
      end
   endtask

   // Inputs change only at the falling edge; outputs are checked there too.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("db",      btn_db_o,      m_db);
      check("press",   btn_press_o,   m_press);
      check("release", btn_release_o, m_rel);
      check("toggle",  btn_toggle_o,  m_tog);
      check("excl",    btn_press_o & btn_release_o, '0);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int       np;
      int       nr;
      btn_vec_t tog_exp;

      rst_n = 1'b0;
      btn_i = 4'b1111;
      @(negedge clk);

      // Reset with buttons held, then release reset.
      steps(3);
      check("rst_db",    btn_db_o,    4'b0000);
      check("rst_press", btn_press_o, 4'b0000);
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 5) check("rst_rel_db_early", btn_db_o, 4'b0000);
         if (k == 6) begin
            check("rst_rel_db",    btn_db_o,    4'b1111);
            check("rst_rel_press", btn_press_o, 4'b1111);
         end
         if (k == 7) check("rst_rel_press_once", btn_press_o, 4'b0000);
      end
      btn_i = 4'b0000;
      steps(10);

      // Clean press and release on bit 0.
      btn_i = 4'b0001;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 5) check("clean_db_early", btn_db_o, 4'b0000);
         if (k == 6) begin
            check("clean_db",    btn_db_o,    4'b0001);
            check("clean_press", btn_press_o, 4'b0001);
         end
      end
      btn_i = 4'b0000;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 6) begin
            check("clean_rel_db", btn_db_o,      4'b0000);
            check("clean_rel",    btn_release_o, 4'b0001);
         end
      end

      // Glitch on bit 1: three cycles high is one short of the filter length.
      np = 0; nr = 0;
      btn_i = 4'b0010;
      for (int k = 0; k < 13; k++) begin
         if (k == 3) btn_i = 4'b0000;
         step();
         np += int'(btn_press_o[1]) + int'(btn_db_o[1]);
         nr += int'(btn_release_o[1]);
      end
      check("glitch_press", 4'(np), 4'd0);
      check("glitch_rel",   4'(nr), 4'd0);

      // Bounce on bit 2, then hold high.
      np = 0; nr = 0;
      for (int k = 0; k < 6; k++) begin
         btn_i = (k % 2 == 0) ? 4'b0100 : 4'b0000;
         step();
         np += int'(btn_press_o[2]);
         nr += int'(btn_release_o[2]);
      end
      btn_i = 4'b0100;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 6) check("bounce_press_edge", btn_press_o, 4'b0100);
         np += int'(btn_press_o[2]);
         nr += int'(btn_release_o[2]);
      end
      check("bounce_press_cnt", 4'(np), 4'd1);
      check("bounce_rel_cnt",   4'(nr), 4'd0);

      // Fresh reset, then all buttons pressed together twice.
      rst_n = 1'b0;
      btn_i = 4'b0000;
      steps(2);
      rst_n = 1'b1;
      steps(4);
`ifdef BTN_DEBOUNCER_TOGGLE_EN
      tog_exp = 4'b1111;
`else
      tog_exp = 4'b0000;
`endif
      for (int pass = 0; pass < 2; pass++) begin
         btn_i = 4'b1111;
         for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 6) check("simul_press", btn_press_o, 4'b1111);
            if (k == 7) check("simul_toggle", btn_toggle_o, (pass == 0) ? tog_exp : 4'b0000);
         end
         btn_i = 4'b0000;
         for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 6) check("simul_release", btn_release_o, 4'b1111);
         end
      end

      // Reset while bit 3 is part-way through its count.
      btn_i = 4'b1000;
      steps(4);
      rst_n = 1'b0;
      step();
      check("midrst_db", btn_db_o, 4'b0000);
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         if (k == 5) check("midrst_db_early", btn_db_o, 4'b0000);
         if (k == 6) begin
            check("midrst_db_rise", btn_db_o,    4'b1000);
            check("midrst_press",   btn_press_o, 4'b1000);
         end
      end

      // Random bouncing buttons with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < NB; k++)
            if ($urandom_range(7) == 0) btn_i[k] = ~btn_i[k];
         rst_n = ($urandom_range(299) != 0);
         step();
      end
      rst_n = 1'b1;
      steps(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_btn_debouncer
